// File: rtl/imm_encoder.sv
// Packs a 64-bit signed immediate into the I/S/B/J bit positions of an RV64 instruction word.
// The word is delivered through a 2-entry skid buffer. Optional range checking is enabled by IMM_RANGE_CHECK_EN.
module imm_encoder #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_base,
    input  logic [63:0]      in_imm,
    input  logic [1:0]       in_imm_src,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_inst,
    output logic             out_err,
    output logic [CNT_W-1:0] enc_count,
    output logic [CNT_W-1:0] err_count
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic             r_in_ready;
    logic [31:0]      r_head_inst;
    logic             r_head_err;
    logic [31:0]      r_tail_inst;
    logic             r_tail_err;
    logic [CNT_W-1:0] r_enc_count;
    logic [CNT_W-1:0] r_err_count;

    logic [31:0]      w_packed;
    logic [31:0]      w_enc_inst;
    logic             w_enc_err;
    logic             w_out_valid;
    logic             w_accept;
    logic             w_drain;

    // Bit scatter: base supplies every non-immediate field.
    always_comb begin
        w_packed = in_base;
        case (in_imm_src)
            2'b00: w_packed[31:20] = in_imm[11:0];
            2'b01: begin
                w_packed[31:25] = in_imm[11:5];
                w_packed[11:7]  = in_imm[4:0];
            end
            2'b10: begin
                w_packed[31]    = in_imm[12];
                w_packed[30:25] = in_imm[10:5];
                w_packed[11:8]  = in_imm[4:1];
                w_packed[7]     = in_imm[11];
            end
            default: begin
                w_packed[31]    = in_imm[20];
                w_packed[30:21] = in_imm[10:1];
                w_packed[20]    = in_imm[11];
                w_packed[19:12] = in_imm[19:12];
            end
        endcase
    end

`ifdef IMM_RANGE_CHECK_EN
    logic w_err;

    always_comb begin
        case (in_imm_src)
            2'b00, 2'b01: w_err = !((&in_imm[63:11]) || !(|in_imm[63:11]));
            2'b10:        w_err = !((&in_imm[63:12]) || !(|in_imm[63:12])) || in_imm[0];
            default:      w_err = !((&in_imm[63:20]) || !(|in_imm[63:20])) || in_imm[0];
        endcase
    end

    // Zeroing the opcode makes an unrepresentable word decode as illegal.
    assign w_enc_inst = w_err ? {in_base[31:7], 7'b0000000} : w_packed;
    assign w_enc_err  = w_err;
`else
    logic w_unused_imm;

    assign w_unused_imm = ^in_imm[63:21];
    assign w_enc_inst   = w_packed;
    assign w_enc_err    = 1'b0;
`endif

    assign w_accept = in_valid & r_in_ready;
    assign w_drain  = w_out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_EMPTY;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_next;
            r_in_ready <= (w_next != ST_TWO);
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_EMPTY: if (w_accept) w_next = ST_ONE;
            ST_ONE: begin
                if (w_accept && !w_drain)      w_next = ST_TWO;
                else if (!w_accept && w_drain) w_next = ST_EMPTY;
            end
            ST_TWO:   if (w_drain) w_next = ST_ONE;
            default:  w_next = ST_EMPTY;
        endcase
    end

    always_comb begin
        w_out_valid = (r_state != ST_EMPTY);
    end

    // In ONE, an accept that coincides with a drain overwrites the head directly.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head_inst <= '0;
            r_head_err  <= 1'b0;
            r_tail_inst <= '0;
            r_tail_err  <= 1'b0;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        r_head_inst <= w_enc_inst;
                        r_head_err  <= w_enc_err;
                    end
                end
                ST_ONE: begin
                    if (w_accept && w_drain) begin
                        r_head_inst <= w_enc_inst;
                        r_head_err  <= w_enc_err;
                    end else if (w_accept) begin
                        r_tail_inst <= w_enc_inst;
                        r_tail_err  <= w_enc_err;
                    end
                end
                ST_TWO: begin
                    if (w_drain) begin
                        r_head_inst <= r_tail_inst;
                        r_head_err  <= r_tail_err;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_enc_count <= '0;
            r_err_count <= '0;
        end else if (w_drain) begin
            r_enc_count <= r_enc_count + 1'b1;
            if (r_head_err) r_err_count <= r_err_count + 1'b1;
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = w_out_valid;
    assign out_inst  = r_head_inst;
    assign out_err   = r_head_err;
    assign enc_count = r_enc_count;
    assign err_count = r_err_count;

endmodule

// File: tb/tb_imm_encoder.sv
// Scoreboard bench for imm_encoder; expectations follow IMM_RANGE_CHECK_EN when it is defined.
module tb_imm_encoder;

    localparam int CNT_W = 16;
`ifdef IMM_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_base;
    logic [63:0]      in_imm;
    logic [1:0]       in_imm_src;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_inst;
    logic             out_err;
    logic [CNT_W-1:0] enc_count;
    logic [CNT_W-1:0] err_count;

    int               tests;
    int               fails;
    logic [32:0]      sb[$];
    logic [CNT_W-1:0] exp_enc;
    logic [CNT_W-1:0] exp_err;

    imm_encoder #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_base    (in_base),
        .in_imm     (in_imm),
        .in_imm_src (in_imm_src),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_inst   (out_inst),
        .out_err    (out_err),
        .enc_count  (enc_count),
        .err_count  (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: keep-mask on the base OR-ed with the immediate bits shifted into place.
    function automatic logic [32:0] model(input logic [31:0] b, input logic [63:0] m, input logic [1:0] s);
        logic [31:0] keep;
        logic [31:0] ib;
        logic        e;
        logic signed [63:0] sm;
        sm = m;
        case (s)
            2'b00: begin
                keep = 32'h000F_FFFF;
                ib   = {m[11:0], 20'h0};
                e    = (sm > 64'sd2047) || (sm < -64'sd2048);
            end
            2'b01: begin
                keep = 32'h01FF_F07F;
                ib   = (32'(m[11:5]) << 25) | (32'(m[4:0]) << 7);
                e    = (sm > 64'sd2047) || (sm < -64'sd2048);
            end
            2'b10: begin
                keep = 32'h01FF_F07F;
                ib   = (32'(m[12]) << 31) | (32'(m[10:5]) << 25) | (32'(m[4:1]) << 8) | (32'(m[11]) << 7);
                e    = (sm > 64'sd4095) || (sm < -64'sd4096) || m[0];
            end
            default: begin
                keep = 32'h0000_0FFF;
                ib   = (32'(m[20]) << 31) | (32'(m[10:1]) << 21) | (32'(m[11]) << 20) | (32'(m[19:12]) << 12);
                e    = (sm > 64'sd1048575) || (sm < -64'sd1048576) || m[0];
            end
        endcase
        if (!RC) e = 1'b0;
        if (e) return {b[31:7], 7'b0000000, 1'b1};
        return {(b & keep) | ib, 1'b0};
    endfunction

    // Monitor: occupancy, counters and drained words against the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            tests++;
            if (out_valid !== (sb.size() != 0)) begin
                fails++;
                $display("FAIL occupancy: out_valid=%0b expected %0b", out_valid, sb.size() != 0);
            end
            tests++;
            if (enc_count !== exp_enc) begin
                fails++;
                $display("FAIL enc_count: got %0d expected %0d", enc_count, exp_enc);
            end
            tests++;
            if (err_count !== exp_err) begin
                fails++;
                $display("FAIL err_count: got %0d expected %0d", err_count, exp_err);
            end
            if (out_valid && out_ready && sb.size() != 0) begin
                logic [32:0] e;
                e = sb.pop_front();
                tests++;
                if ({out_inst, out_err} !== e) begin
                    fails++;
                    $display("FAIL drain_word: got inst=%08h err=%0b expected inst=%08h err=%0b",
                             out_inst, out_err, e[32:1], e[0]);
                end
                exp_enc = exp_enc + 1'b1;
                if (e[0]) exp_err = exp_err + 1'b1;
            end
            if (in_valid && in_ready) sb.push_back(model(in_base, in_imm, in_imm_src));
        end
    end

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst     = 1'b0;
        sb.delete();
        exp_enc = '0;
        exp_err = '0;
    endtask

    task automatic send(input logic [31:0] b, input logic [63:0] m, input logic [1:0] s, output int waited);
        waited     = 0;
        in_valid   = 1'b1;
        in_base    = b;
        in_imm     = m;
        in_imm_src = s;
        @(negedge clk);
        while (!in_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: in_ready=%0b expected 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_empty();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (sb.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: %0d entries left expected 0", sb.size());
        end
    endtask

    task automatic test_reset();
        do_reset();
        tests++;
        if ({out_valid, in_ready, out_err} !== 3'b010) begin
            fails++;
            $display("FAIL reset_flags: valid/ready/err=%03b expected 010", {out_valid, in_ready, out_err});
        end
        tests++;
        if ({out_inst, enc_count, err_count} !== '0) begin
            fails++;
            $display("FAIL reset_data: inst=%08h enc=%0d err=%0d expected 0", out_inst, enc_count, err_count);
        end
    endtask

    task automatic test_i_type();
        int w;
        out_ready = 1'b1;
        send(32'h0000_0013, -64'sd1, 2'b00, w);
        tests++;
        if ({out_valid, out_inst, out_err} !== {1'b1, 32'hFFF0_0013, 1'b0}) begin
            fails++;
            $display("FAIL i_type: valid=%0b inst=%08h err=%0b expected 1 fff00013 0", out_valid, out_inst, out_err);
        end
        @(posedge clk);
        #1;
        tests++;
        if (enc_count !== 16'd1) begin
            fails++;
            $display("FAIL i_count: got %0d expected 1", enc_count);
        end
    endtask

    task automatic test_mapping();
        logic [31:0] bases[3] = '{32'h0000_3023, 32'h0000_0063, 32'h0000_006F};
        logic [63:0] imms[3]  = '{64'h7F8, -64'sd4, 64'h800};
        logic [1:0]  srcs[3]  = '{2'b01, 2'b10, 2'b11};
        logic [31:0] want[3]  = '{32'h7E00_3C23, 32'hFE00_0EE3, 32'h0010_006F};
        int w;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send(bases[i], imms[i], srcs[i], w);
            tests++;
            if (out_inst !== want[i] || out_err !== 1'b0) begin
                fails++;
                $display("FAIL mapping_%0d: inst=%08h err=%0b expected %08h 0", i, out_inst, out_err, want[i]);
            end
            wait_empty();
        end
    endtask

    task automatic test_backpressure();
        logic [32:0] a;
        int w;
        do_reset();
        out_ready = 1'b0;
        a = model(32'h0000_0013, 64'd5, 2'b00);
        send(32'h0000_0013, 64'd5, 2'b00, w);
        send(32'h0000_2023, -64'sd7, 2'b01, w);
        in_valid   = 1'b1;
        in_base    = 32'h0000_0063;
        in_imm     = 64'd16;
        in_imm_src = 2'b10;
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (in_ready !== 1'b0 || out_inst !== a[32:1] || out_valid !== 1'b1) begin
                fails++;
                $display("FAIL backpressure_hold_%0d: ready=%0b valid=%0b inst=%08h expected 0 1 %08h",
                         i, in_ready, out_valid, out_inst, a[32:1]);
            end
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        send(32'h0000_0063, 64'd16, 2'b10, w);
        wait_empty();
        tests++;
        if (enc_count !== 16'd3) begin
            fails++;
            $display("FAIL backpressure_count: got %0d expected 3", enc_count);
        end
    endtask

    task automatic test_back_to_back();
        int w;
        out_ready = 1'b1;
        wait_empty();
        for (int i = 0; i < 8; i++) begin
            send({$urandom}, {$urandom, $urandom}, 2'($urandom_range(3, 0)), w);
            tests++;
            if (w != 0 || in_ready !== 1'b1 || out_valid !== 1'b1) begin
                fails++;
                $display("FAIL back_to_back_%0d: waited=%0d ready=%0b valid=%0b expected 0 1 1",
                         i, w, in_ready, out_valid);
            end
        end
        wait_empty();
    endtask

    task automatic test_range();
        int w;
        do_reset();
        out_ready = 1'b1;
        send(32'h0000_0013, 64'd2048, 2'b00, w);
        tests++;
        if (out_err !== RC || out_inst[6:0] !== (RC ? 7'h00 : 7'h13)) begin
            fails++;
            $display("FAIL range_i_pos: err=%0b op=%02h expected %0b %02h", out_err, out_inst[6:0], RC, RC ? 7'h00 : 7'h13);
        end
        wait_empty();
        tests++;
        if (err_count !== 16'(RC)) begin
            fails++;
            $display("FAIL range_err_count: got %0d expected %0d", err_count, RC);
        end
        send(32'h0000_0063, 64'd3, 2'b10, w);
        tests++;
        if (out_err !== RC) begin
            fails++;
            $display("FAIL range_b_odd: err=%0b expected %0b", out_err, RC);
        end
        wait_empty();
        send(32'h0000_0013, -64'sd2048, 2'b00, w);
        tests++;
        if (out_err !== 1'b0 || out_inst !== 32'h8000_0013) begin
            fails++;
            $display("FAIL range_i_min: err=%0b inst=%08h expected 0 80000013", out_err, out_inst);
        end
        wait_empty();
    endtask

    task automatic test_reset_mid();
        int w;
        out_ready = 1'b0;
        send(32'h0000_0013, 64'd1, 2'b00, w);
        send(32'h0000_0013, 64'd2, 2'b00, w);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        exp_enc = '0;
        exp_err = '0;
        tests++;
        if ({out_valid, in_ready} !== 2'b01 || {out_inst, out_err, enc_count, err_count} !== '0) begin
            fails++;
            $display("FAIL reset_mid: valid=%0b ready=%0b inst=%08h enc=%0d err=%0d expected 0 1 0 0 0",
                     out_valid, in_ready, out_inst, enc_count, err_count);
        end
        out_ready = 1'b1;
        send(32'h0000_0067, 64'd12, 2'b00, w);
        tests++;
        if (out_inst !== 32'h00C0_0067) begin
            fails++;
            $display("FAIL reset_after: inst=%08h expected 00c00067", out_inst);
        end
        wait_empty();
        tests++;
        if (enc_count !== 16'd1) begin
            fails++;
            $display("FAIL reset_after_count: got %0d expected 1", enc_count);
        end
    endtask

    initial begin
        tests      = 0;
        fails      = 0;
        exp_enc    = '0;
        exp_err    = '0;
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_base    = '0;
        in_imm     = '0;
        in_imm_src = 2'b00;
        out_ready  = 1'b0;
        test_reset();
        test_i_type();
        test_mapping();
        test_backpressure();
        test_back_to_back();
        test_range();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
